pattern_stim_gen: RTL and testbench
===================================

// Module: pattern_stim_gen
// PURPOSE
//   Parametrised multi-channel serial pattern generator for stimulating combinational DUTs (e.g. nor_gate).
//   Loads one LEN-bit pattern per channel and plays all channels out in lockstep, MSB first.
//   Each bit is held for STEP_DIV clocks; supports one-shot or continuous loop, abort, and optional response capture.
//   Sits between testbench/control logic and the DUT inputs; replaces hand-written per-bit stimulus loops.
// PARAMETERS
//   CHANNELS  3   number of parallel output channels (>=1)
//   LEN       19  pattern length in bits per channel (>=2)
//   STEP_DIV  1   clocks each bit is held (>=1)
//   IDX_W     $clog2(LEN)  width of bit index (derived, not overridden)
// PORTS
//   clk        in   1               system clock, rising edge
//   reset_n    in   1               asynchronous reset, active-low
//   pat_i      in   CHANNELS*LEN    patterns; channel c bit n = pat_i[c*LEN+n]
//   start_i    in   1               1-cycle start request (honoured only in IDLE)
//   abort_i    in   1               stop playback immediately
//   loop_i     in   1               1 = restart pattern after last bit
//   resp_i     in   1               DUT response bit (capture feature only)
//   out_o      out  CHANNELS        current bit of every channel
//   step_o     out  1               pulses on first cycle each new bit is presented
//   bit_idx_o  out  IDX_W           index of bit currently on out_o
//   busy_o     out  1               high while RUN
//   done_o     out  1               1-cycle pulse at end of a non-looping pass
//   cap_o      out  LEN             captured responses (capture feature only)
// BEHAVIOUR
//   - Reset (async, reset_n=0): state IDLE; out_o=0, step_o=0, bit_idx_o=0, busy_o=0, done_o=0, cap_o=0, shadow reg=0.
//   - States: IDLE, RUN. IDLE->RUN on start_i & !abort_i; RUN->IDLE on abort_i or end of pass with loop_i=0.
//   - Start: pat_i latched into shadow register on start cycle; pat_i ignored afterwards until next start.
//   - Latency: cycle after start, busy_o=1, step_o=1, bit_idx_o=LEN-1, out_o[c]=shadow[c*LEN+LEN-1].
//   - Each bit held exactly STEP_DIV clocks (divider counter 0..STEP_DIV-1); then index decrements, step_o pulses.
//   - End of pass = last clock of bit 0. loop_i sampled there:
//       loop_i=1: bit_idx_o wraps to LEN-1 from shadow, step_o pulses, no done_o, busy_o stays 1.
//       loop_i=0: next cycle IDLE, busy_o=0, done_o=1 for one cycle, out_o holds bit 0 values.
//   - One-shot pass duration = LEN*STEP_DIV clocks of busy_o.
//   - start_i while RUN: ignored. start_i & abort_i same cycle in IDLE: abort wins, stays IDLE.
//   - abort_i in RUN: next cycle IDLE, out_o=0, busy_o=0, step_o=0, no done_o; cap_o keeps partial data.
//   - abort_i in IDLE: no effect.
//   - reset_n asserted mid-pass: all outputs return to reset values immediately (async).
//   - step_o and done_o are never high in the same cycle.
// CONFIGURATION
//   PATGEN_CAPTURE_EN defined:
//     resp_i sampled on last clock of each bit period; shifted into cap_o LSB-in (cap_o <= {cap_o[LEN-2:0],resp_i}).
//     cap_o cleared to 0 on accepted start; after a full pass cap_o[LEN-1] = response to first bit.
//     In loop mode capture continues, cap_o always holds the last LEN responses.
//   PATGEN_CAPTURE_EN undefined: no capture register; cap_o tied to 0; resp_i unused. Ports identical.
// TESTING
//   1 CHANNELS=3,LEN=19,STEP_DIV=1; pat ch0=19'b0111111000011110000, ch1=19'b0000111100001111000,
//     ch2=19'b0010010001000100010; pulse start -> out_o follows MSB first, busy_o high 19 clocks, done_o one pulse.
//   2 Same as 1 with CAPTURE_EN, resp_i = NOR(out_o) -> at done_o, cap_o = 19'b1000000010100000101.
//   3 STEP_DIV=4, LEN=4, pat ch0=4'b1010 -> each bit held 4 clocks, step_o every 4th clock, busy_o 16 clocks.
//   4 loop_i=1 for 3 passes then 0 -> bit_idx_o wraps 0->LEN-1 without gap, single done_o after 4th pass.
//   5 abort_i at bit_idx_o=10 -> next cycle out_o=0, busy_o=0, no done_o; start+abort same cycle -> stays IDLE.
//   6 reset_n low mid-pass, start_i during RUN -> outputs zero asynchronously; mid-run start ignored, pattern unchanged.

Source files
------------

// File: rtl/pattern_stim_gen.sv
`default_nettype none
// pattern_stim_gen: multi-channel serial pattern player, MSB first, each bit held STEP_DIV clocks.
// Optional response capture into cap_o is enabled by defining PATGEN_CAPTURE_EN.
module pattern_stim_gen #(
  parameter int CHANNELS = 3,
  parameter int LEN      = 19,
  parameter int STEP_DIV = 1,
  parameter int IDX_W    = $clog2(LEN)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [CHANNELS*LEN-1:0] pat_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic                    loop_i,
  input  logic                    resp_i,
  output logic [CHANNELS-1:0]     out_o,
  output logic                    step_o,
  output logic [IDX_W-1:0]        bit_idx_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [LEN-1:0]          cap_o
);

  localparam int               DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                       state, state_nxt;
  logic [CHANNELS-1:0][LEN-1:0] shadow, shadow_nxt, src_pat;
  logic [DIV_W-1:0]             div_cnt, div_nxt;
  logic [IDX_W-1:0]             idx_nxt, sel_idx;
  logic [CHANNELS-1:0]          out_nxt, sel_bits;
  logic                         step_nxt, busy_nxt, done_nxt;
  logic                         bit_end, cap_clr;

  // On the start cycle the new bit comes straight from pat_i; afterwards from the shadow copy.
  assign src_pat = (state == IDLE) ? pat_i : shadow;
  assign sel_idx = ((state == IDLE) || (bit_idx_o == '0)) ? LAST_IDX : bit_idx_o - IDX_W'(1);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    assign sel_bits[c] = src_pat[c][sel_idx];
  end

  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    div_nxt    = div_cnt;
    idx_nxt    = bit_idx_o;
    out_nxt    = out_o;
    step_nxt   = 1'b0;
    busy_nxt   = busy_o;
    done_nxt   = 1'b0;
    bit_end    = 1'b0;
    cap_clr    = 1'b0;
    case (state)
      IDLE: begin
        if (start_i && !abort_i) begin
          state_nxt  = RUN;
          shadow_nxt = pat_i;
          div_nxt    = '0;
          idx_nxt    = LAST_IDX;
          out_nxt    = sel_bits;
          step_nxt   = 1'b1;
          busy_nxt   = 1'b1;
          cap_clr    = 1'b1;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_nxt = IDLE;
          out_nxt   = '0;
          busy_nxt  = 1'b0;
          idx_nxt   = '0;
          div_nxt   = '0;
        end else if (div_cnt != DIV_LAST) begin
          div_nxt = div_cnt + DIV_W'(1);
        end else begin
          bit_end = 1'b1;
          div_nxt = '0;
          if ((bit_idx_o != '0) || loop_i) begin
            idx_nxt  = sel_idx;
            out_nxt  = sel_bits;
            step_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      shadow    <= '0;
      div_cnt   <= '0;
      bit_idx_o <= '0;
      out_o     <= '0;
      step_o    <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      state     <= state_nxt;
      shadow    <= shadow_nxt;
      div_cnt   <= div_nxt;
      bit_idx_o <= idx_nxt;
      out_o     <= out_nxt;
      step_o    <= step_nxt;
      busy_o    <= busy_nxt;
      done_o    <= done_nxt;
    end
  end

`ifdef PATGEN_CAPTURE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_o <= '0;
    end else if (cap_clr) begin
      cap_o <= '0;
    end else if (bit_end) begin
      cap_o <= {cap_o[LEN-2:0], resp_i};
    end
  end
`else
  logic unused_capture;
  assign unused_capture = ^{resp_i, bit_end, cap_clr};
  assign cap_o          = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pattern_stim_gen.sv
`default_nettype none
// tb_pattern_stim_gen: scoreboard bench driving a 3x19 (STEP_DIV=1) and a 1x4 (STEP_DIV=4) instance.
module tb_pattern_stim_gen;
  localparam int CH   = 3;
  localparam int LEN  = 19;
  localparam int LEN2 = 4;
  localparam int DIV2 = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [CH*LEN-1:0] pat = '0;
  logic              start = 1'b0, abort = 1'b0, loop = 1'b0;
  logic              resp;
  logic [CH-1:0]     out;
  logic              step, busy, done;
  logic [4:0]        idx;
  logic [LEN-1:0]    cap;

  logic [LEN2-1:0]   pat2 = '0;
  logic              start2 = 1'b0, abort2 = 1'b0, loop2 = 1'b0;
  logic              out2, step2, busy2, done2;
  logic [1:0]        idx2;
  logic [LEN2-1:0]   cap2;

  int checks = 0;
  int passes = 0;
  logic [10:0] q1[$];
  logic [5:0]  q2[$];
  logic [10:0] obs1;
  logic [5:0]  obs2;

  always #5 clk = ~clk;
  assign resp = ~|out;
  assign obs1 = {busy, step, done, idx, out};
  assign obs2 = {busy2, step2, done2, idx2, out2};

  pattern_stim_gen #(.CHANNELS(CH), .LEN(LEN), .STEP_DIV(1)) dut (
    .clk(clk), .reset_n(reset_n), .pat_i(pat), .start_i(start), .abort_i(abort),
    .loop_i(loop), .resp_i(resp), .out_o(out), .step_o(step), .bit_idx_o(idx),
    .busy_o(busy), .done_o(done), .cap_o(cap)
  );

  pattern_stim_gen #(.CHANNELS(1), .LEN(LEN2), .STEP_DIV(DIV2)) dut2 (
    .clk(clk), .reset_n(reset_n), .pat_i(pat2), .start_i(start2), .abort_i(abort2),
    .loop_i(loop2), .resp_i(1'b0), .out_o(out2), .step_o(step2), .bit_idx_o(idx2),
    .busy_o(busy2), .done_o(done2), .cap_o(cap2)
  );

  function automatic logic [2:0] bits_at(input logic [CH*LEN-1:0] p, input int n);
    logic [2:0] r;
    for (int c = 0; c < CH; c++) r[c] = p[c*LEN+n];
    return r;
  endfunction

  function automatic logic [CH*LEN-1:0] rand_pat();
    logic [CH*LEN-1:0] p;
    for (int i = 0; i < CH*LEN; i++) p[i] = 1'($urandom_range(0, 1));
    return p;
  endfunction

  // Expected per-cycle view of dut for npass back-to-back passes, then done and one idle cycle.
  task automatic push_run(input logic [CH*LEN-1:0] p, input int npass);
    for (int k = 0; k < npass*LEN; k++)
      q1.push_back({1'b1, 1'b1, 1'b0, 5'(LEN-1-k%LEN), bits_at(p, LEN-1-k%LEN)});
    q1.push_back({1'b0, 1'b0, 1'b1, 5'd0, bits_at(p, 0)});
    q1.push_back({1'b0, 1'b0, 1'b0, 5'd0, bits_at(p, 0)});
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({obs1, cap, obs2, cap2} !== '0) $display("FAIL reset_state: got=%h/%h required=0", obs1, cap);
    else passes++;
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({obs1, obs2} !== '0) $display("FAIL reset_idle: got=%h/%h required=0", obs1, obs2);
    else passes++;
  endtask

  task automatic test_one_shot();
    logic [10:0] e;
    int n, busy_cnt, done_cnt;
    busy_cnt = 0; done_cnt = 0;
    pat = {19'b0010010001000100010, 19'b0000111100001111000, 19'b0111111000011110000};
    push_run(pat, 1);
    n = q1.size();
    start = 1'b1;
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      start = 1'b0;
      busy_cnt += int'(busy);
      done_cnt += int'(done);
      e = q1.pop_front();
      checks++;
      if (obs1 !== e) $display("FAIL one_shot cyc%0d: got=%h required=%h", j, obs1, e);
      else passes++;
    end
    checks++;
    if (busy_cnt != LEN || done_cnt != 1)
      $display("FAIL one_shot_len: busy=%0d done=%0d required busy=%0d done=1", busy_cnt, done_cnt, LEN);
    else passes++;
  endtask

  task automatic test_capture();
    logic [10:0]    e;
    logic [LEN-1:0] exp_cap;
    int n;
`ifdef PATGEN_CAPTURE_EN
    exp_cap = 19'b1000000010100000101;
`else
    exp_cap = '0;
`endif
    push_run(pat, 1);
    n = q1.size();
    start = 1'b1;
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      start = 1'b0;
      e = q1.pop_front();
      checks++;
      if (obs1 !== e) $display("FAIL capture_run cyc%0d: got=%h required=%h", j, obs1, e);
      else passes++;
      if (j == 0) begin
        checks++;
        if (cap !== '0) $display("FAIL capture_clear: got=%b required=0", cap);
        else passes++;
      end
      if (j == LEN) begin
        checks++;
        if (cap !== exp_cap) $display("FAIL capture_value: got=%b required=%b", cap, exp_cap);
        else passes++;
      end
    end
  endtask

  task automatic test_step_div();
    logic [5:0] e;
    int n;
    pat2 = 4'b1010;
    for (int j = 0; j < LEN2*DIV2; j++)
      q2.push_back({1'b1, 1'(j % DIV2 == 0), 1'b0, 2'(3 - j/DIV2), pat2[3 - j/DIV2]});
    q2.push_back({1'b0, 1'b0, 1'b1, 2'd0, pat2[0]});
    q2.push_back({1'b0, 1'b0, 1'b0, 2'd0, pat2[0]});
    n = q2.size();
    start2 = 1'b1;
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      start2 = 1'b0;
      e = q2.pop_front();
      checks++;
      if (obs2 !== e) $display("FAIL step_div cyc%0d: got=%h required=%h", j, obs2, e);
      else passes++;
    end
    checks++;
    if (cap2 !== '0) $display("FAIL step_div_cap: got=%b required=0", cap2);
    else passes++;
  endtask

  task automatic test_loop();
    logic [10:0] e;
    int n;
    pat = rand_pat();
    push_run(pat, 4);
    n = q1.size();
    loop = 1'b1;
    start = 1'b1;
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (j == 3*LEN) loop = 1'b0;
      e = q1.pop_front();
      checks++;
      if (obs1 !== e) $display("FAIL loop cyc%0d: got=%h required=%h", j, obs1, e);
      else passes++;
    end
  endtask

  task automatic test_abort();
    logic [10:0]    e;
    logic [LEN-1:0] exp_cap;
    pat = rand_pat();
    exp_cap = '0;
`ifdef PATGEN_CAPTURE_EN
    for (int b = LEN-1; b > 10; b--) exp_cap = {exp_cap[LEN-2:0], ~|bits_at(pat, b)};
`endif
    for (int k = 0; k < 9; k++)
      q1.push_back({1'b1, 1'b1, 1'b0, 5'(LEN-1-k), bits_at(pat, LEN-1-k)});
    start = 1'b1;
    for (int j = 0; j < 9; j++) begin
      @(posedge clk); #1;
      start = 1'b0;
      e = q1.pop_front();
      checks++;
      if (obs1 !== e) $display("FAIL abort_run cyc%0d: got=%h required=%h", j, obs1, e);
      else passes++;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if ({busy, step, done, out} !== '0) $display("FAIL abort_stop: got=%h required=0", {busy, step, done, out});
    else passes++;
    checks++;
    if (cap !== exp_cap) $display("FAIL abort_cap: got=%b required=%b", cap, exp_cap);
    else passes++;
    start = 1'b1;
    abort = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if ({busy, done, step} !== 3'b000) $display("FAIL abort_idle cyc%0d: got=%b required=000", j, {busy, done, step});
      else passes++;
    end
    abort = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [10:0]       e;
    logic [CH*LEN-1:0] p1;
    p1 = rand_pat();
    pat = p1;
    for (int k = 0; k < 10; k++)
      q1.push_back({1'b1, 1'b1, 1'b0, 5'(LEN-1-k), bits_at(p1, LEN-1-k)});
    start = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (j == 3) begin
        pat = ~p1;
        start = 1'b1;
      end
      e = q1.pop_front();
      checks++;
      if (obs1 !== e) $display("FAIL run_start_ignored cyc%0d: got=%h required=%h", j, obs1, e);
      else passes++;
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({obs1, cap} !== '0) $display("FAIL async_reset: got=%h/%h required=0", obs1, cap);
    else passes++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs1 !== '0) $display("FAIL reset_release: got=%h required=0", obs1);
    else passes++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_one_shot();
    test_capture();
    test_step_div();
    test_loop();
    test_abort();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
